// File: rtl/crc8_pkt_framer.sv
// Packet framer in front of a bit-serial CRC-8 byte stage: feeds each byte to the
// stage, forwards it downstream, then appends the CRC (generate) or reports the residue (check).
module crc8_pkt_framer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       check_mode,
  output logic [7:0] crc_byte,
  output logic       crc_en,
  output logic       crc_clr,
  input  logic [7:0] crc_value,
  input  logic       crc_done,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       crc_ok,
  output logic       crc_err,
  output logic       pkt_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_WAIT,
    S_SEND,
    S_APPEND,
    S_STATUS
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       last_q, last_d;
  logic       mode_q, mode_d;
  logic       first_q, first_d;
  logic [7:0] crc_q, crc_d;
  logic [7:0] tmo_q, tmo_d;

  logic       in_ready_q, in_ready_d;
  logic [7:0] crc_byte_q, crc_byte_d;
  logic       crc_en_q, crc_en_d;
  logic       crc_clr_q, crc_clr_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_last_q, out_last_d;
  logic       out_valid_q, out_valid_d;
  logic       crc_ok_q, crc_ok_d;
  logic       crc_err_q, crc_err_d;
  logic       pkt_err_q, pkt_err_d;

  always_comb begin
    // NOTE: every _d starts from its _q (or a pulse default) so no branch leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    data_d    = data_q;
    last_d    = last_q;
    mode_d    = mode_q;
    first_d   = first_q;
    crc_d     = crc_q;
    tmo_d     = tmo_q;
    pkt_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          last_d = in_last;
          if (first_q) begin
            mode_d  = check_mode;
            first_d = 1'b0;
            state_d = S_CLR;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_CLR: state_d = S_LOAD;
      S_LOAD: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done pulse on the final timeout cycle still completes the byte.
        if (crc_done) begin
          crc_d   = crc_value;
          state_d = S_SEND;
        end else if (tmo_q == TMO_LAST) begin
          pkt_err_d = 1'b1;
          first_d   = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          if (!last_q)     state_d = S_IDLE;
          else if (mode_q) state_d = S_STATUS;
          else             state_d = S_APPEND;
        end
      end
      S_APPEND: begin
        if (out_ready) begin
          first_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_STATUS: begin
        first_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    in_ready_d  = (state_d == S_IDLE);
    crc_clr_d   = (state_d == S_CLR);
    crc_en_d    = (state_d == S_LOAD);
    crc_byte_d  = (state_d == S_LOAD) ? data_d : crc_byte_q;
    out_valid_d = (state_d == S_SEND) || (state_d == S_APPEND);
    out_data_d  = 8'h00;
    out_last_d  = 1'b0;
    if (state_d == S_SEND) begin
      out_data_d = data_q;
      out_last_d = last_q & mode_q;
    end else if (state_d == S_APPEND) begin
      out_data_d = crc_q;
      out_last_d = 1'b1;
    end
    crc_ok_d  = (state_d == S_STATUS) && (crc_q == 8'h00);
    crc_err_d = (state_d == S_STATUS) && (crc_q != 8'h00);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      last_q      <= 1'b0;
      mode_q      <= 1'b0;
      first_q     <= 1'b1;
      crc_q       <= '0;
      tmo_q       <= '0;
      in_ready_q  <= 1'b1;
      crc_byte_q  <= '0;
      crc_en_q    <= 1'b0;
      crc_clr_q   <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      last_q      <= last_d;
      mode_q      <= mode_d;
      first_q     <= first_d;
      crc_q       <= crc_d;
      tmo_q       <= tmo_d;
      in_ready_q  <= in_ready_d;
      crc_byte_q  <= crc_byte_d;
      crc_en_q    <= crc_en_d;
      crc_clr_q   <= crc_clr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      crc_ok_q    <= crc_ok_d;
      crc_err_q   <= crc_err_d;
      pkt_err_q   <= pkt_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign crc_byte  = crc_byte_q;
  assign crc_en    = crc_en_q;
  assign crc_clr   = crc_clr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign crc_ok    = crc_ok_q;
  assign crc_err   = crc_err_q;
  assign pkt_err   = pkt_err_q;

endmodule
